// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM encodings and nibble width.
package nibble_serial_add_ctrl_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_adder4.sv
// Combinational 4-bit ripple-carry adder built from full-adder cells.
module nibble_adder4
  import nibble_serial_add_ctrl_pkg::*;
(
  output logic             cout,
  output logic [NIB_W-1:0] sum,
  input  logic [NIB_W-1:0] in1,
  input  logic [NIB_W-1:0] in2,
  input  logic             cin
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
    assign c[i+1]   = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder sequenced one nibble per clock through a shared 4-bit adder.
// Optional subtract mode (sub port) is enabled by defining NIBBLE_SUB_EN.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned NIB = nib_count(WIDTH);
  localparam int unsigned CW  = $clog2(NIB) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d, result_shift;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NIB_W-1:0] add_sum;
  logic             add_cout;
  logic             last_step;

  nibble_adder4 u_adder (
    .cout (add_cout),
    .sum  (add_sum),
    .in1  (opa_q[NIB_W-1:0]),
    .in2  (opb_q[NIB_W-1:0]),
    .cin  (carry_q)
  );

  assign last_step = (cnt_q == CW'(NIB - 1));

  // Each new nibble enters at the MSB end so the first one lands at the LSB after NIB steps.
  if (WIDTH == NIB_W) begin : g_single
    assign result_shift = add_sum;
  end else begin : g_multi
    assign result_shift = {add_sum, result_q[WIDTH-1:NIB_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    if (state_q == ST_IDLE && start) begin
      opa_d   = a;
      cnt_d   = '0;
`ifdef NIBBLE_SUB_EN
      opb_d   = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
`else
      opb_d   = b;
      carry_d = cin;
`endif
    end else if (state_q == ST_RUN) begin
      opa_d    = opa_q >> NIB_W;
      opb_d    = opb_q >> NIB_W;
      carry_d  = add_cout;
      cnt_d    = cnt_q + CW'(1);
      result_d = result_shift;
      if (last_step) cout_d = add_cout;
    end
  end

  always_comb begin
    busy   = (state_q == ST_RUN);
    done   = (state_q == ST_DONE);
    result = result_q;
    cout   = cout_q;
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: table vectors, random ops against an arithmetic model, corner sequences.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] result16;

  logic        start4 = 1'b0, cin4 = 1'b0, sub4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, cout4;
  logic [3:0]  result4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start16),
    .a      (a16),
    .b      (b16),
    .cin    (cin16),
`ifdef NIBBLE_SUB_EN
    .sub    (sub16),
`endif
    .busy   (busy16),
    .done   (done16),
    .result (result16),
    .cout   (cout16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .cin    (cin4),
`ifdef NIBBLE_SUB_EN
    .sub    (sub4),
`endif
    .busy   (busy4),
    .done   (done4),
    .result (result4),
    .cout   (cout4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_r;
    logic        exp_c;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, subtract expressed as a difference and a no-borrow flag.
  task automatic model16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input logic tsub, output logic [15:0] r, output logic c);
    int unsigned s;
    if (tsub) begin
      r = 16'(int'(ta) - int'(tb_));
      c = (ta >= tb_);
    end else begin
      s = int'(ta) + int'(tb_) + int'(tc);
      r = s[15:0];
      c = s[16];
    end
  endtask

  task automatic run16(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic tsub, input logic [15:0] er, input logic ec);
    int lat = 0, pulses = 0;
    logic [15:0] got_r = '0;
    logic        got_c = 1'b0;
    logic        busy_seen = 1'b0;
    @(negedge clk);
    a16 = ta; b16 = tb_; cin16 = tc; sub16 = tsub; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    sub16 = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) busy_seen = busy16;
      if (done16) begin
        pulses++;
        if (lat == 0) begin
          lat = i; got_r = result16; got_c = cout16;
        end
      end
    end
    check({nm, " busy"}, 32'(busy_seen), 32'd1);
    check({nm, " latency"}, 32'(lat), 32'd4);
    check({nm, " pulses"}, 32'(pulses), 32'd1);
    check({nm, " result"}, 32'(got_r), 32'(er));
    check({nm, " cout"}, 32'(got_c), 32'(ec));
  endtask

  task automatic run4(input string nm, input logic [3:0] ta, input logic [3:0] tb_,
                      input logic tc);
    int lat = 0, pulses = 0;
    int unsigned s;
    logic [3:0] got_r = '0;
    logic       got_c = 1'b0;
    s = int'(ta) + int'(tb_) + int'(tc);
    @(negedge clk);
    a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        pulses++;
        if (lat == 0) begin
          lat = i; got_r = result4; got_c = cout4;
        end
      end
    end
    check({nm, " latency"}, 32'(lat), 32'd1);
    check({nm, " pulses"}, 32'(pulses), 32'd1);
    check({nm, " result"}, 32'(got_r), 32'(s[3:0]));
    check({nm, " cout"}, 32'(got_c), 32'(s[4]));
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] ra, rb, er;
    logic        rc, ec;
    int pulses;

    vecs[0] = '{a: 16'h1234, b: 16'h1111, cin: 1'b0, exp_r: 16'h2345, exp_c: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, exp_r: 16'h0000, exp_c: 1'b1};
    vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, exp_r: 16'hFFFF, exp_c: 1'b1};
    vecs[3] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, exp_r: 16'h0000, exp_c: 1'b0};
    vecs[4] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, exp_r: 16'h0000, exp_c: 1'b1};
    vecs[5] = '{a: 16'h0FFF, b: 16'h0001, cin: 1'b1, exp_r: 16'h1001, exp_c: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy16), 32'd0);
    check("reset done", 32'(done16), 32'd0);
    check("reset result", 32'(result16), 32'd0);
    check("reset cout", 32'(cout16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
            vecs[i].exp_r, vecs[i].exp_c);

    // Result and cout hold in IDLE after the last vector.
    repeat (3) @(posedge clk);
    #1;
    check("hold result", 32'(result16), 32'h1001);
    check("hold busy", 32'(busy16), 32'd0);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      model16(ra, rb, rc, 1'b0, er, ec);
      run16($sformatf("rand%0d", i), ra, rb, rc, 1'b0, er, ec);
    end

    // start held high with changing operands: only the first request is processed.
    pulses = 0;
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      #1;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      @(posedge clk);
      #1;
      if (done16) pulses++;
      if (i == 4) begin
        check("held start done", 32'(done16), 32'd1);
        check("held start result", 32'(result16), 32'h2345);
      end
    end
    check("held start idle busy", 32'(busy16), 32'd0);
    check("held start idle done", 32'(done16), 32'd0);
    start16 = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done16) pulses++;
    end
    check("held start pulses", 32'(pulses), 32'd1);
    run16("after held", 16'h4321, 16'h0FFF, 1'b1, 1'b0, 16'h5321, 1'b0);

    // Leave cout=1 so the async reset visibly clears it.
    run16("pre reset", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    pulses = 0;
    @(negedge clk);
    a16 = 16'h00F0; b16 = 16'h0010; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy16), 32'd0);
    check("abort done", 32'(done16), 32'd0);
    check("abort result", 32'(result16), 32'd0);
    check("abort cout", 32'(cout16), 32'd0);
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done16) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done16) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    run16("after reset", 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0);

    run4("w4 plan", 4'h9, 4'h8, 1'b1);
    run4("w4 max", 4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 6; i++)
      run4($sformatf("w4 rand%0d", i), 4'($urandom), 4'($urandom), 1'($urandom));

`ifdef NIBBLE_SUB_EN
    run16("sub 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run16("sub 7-5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      model16(ra, rb, rc, 1'b1, er, ec);
      run16($sformatf("sub rand%0d", i), ra, rb, rc, 1'b1, er, ec);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
